bram_port_arbiter: RTL and testbench

Shares one BRAM port (write and read) between NUM_REQ datapath clients: systolic-array write-back, the softmax/layernorm write-back, and the read logic feeding the array. It sits directly in front of each activation/weight BRAM. Each burst is granted atomically with round-robin fairness, which keeps a tile's strided write sequence uninterrupted. Read data returns to the client that issued the read, tagged through a latency-matched pipeline.

---
 rtl/bram_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between NUM_REQ clients.
// Each burst is granted atomically, and clients take turns in round-robin order.
// The BRAM strobes are combinational from the owner's lanes.
// Each read beat pushes the owner id into a READ_LATENCY-deep tag pipe, which
// steers the returned data back to the client that issued the read.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant held for MAX_HOLD cycles.
module bram_port_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_HOLD     = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_wdata,
  input  logic [DATA_WIDTH-1:0]         bram_rdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]    timeout_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                             state_q, state_d;
  logic [NUM_REQ-1:0]                 gnt_q, gnt_d;
  logic [ID_W-1:0]                    owner_q, owner_d;
  logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [READ_LATENCY-1:0]            tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

  logic            in_busy;
  logic            beat;
  logic            burst_done;
  logic            hold_expired;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] next_ptr;
  int unsigned     idx;

  assign in_busy    = (state_q == BUSY);
  assign beat       = in_busy & req[owner_q];
  assign burst_done = beat & last[owner_q];
  assign next_ptr   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign bram_en    = beat;
  assign bram_we    = beat & we[owner_q];
  assign bram_addr  = in_busy ? addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bram_wdata = in_busy ? wdata[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rdata      = bram_rdata;
  assign gnt        = gnt_q;
  assign busy       = in_busy;

  // Round-robin search for the first requester at or after rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Grant FSM next state: grant in IDLE, release on last beat or hold expiry
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d        = BUSY;
          gnt_d[win_id]  = 1'b1;
          owner_d        = win_id;
        end
      end
      BUSY: begin
        if (burst_done || hold_expired) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read tag pipe: stage 0 captures this cycle's read beat, later stages shift
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = bram_en & ~bram_we;
    tag_id_d[0]  = owner_q;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // Decode the oldest tag into a one-hot read-return strobe
  always_comb begin
    rvalid = '0;
    if (tag_vld_q[READ_LATENCY-1]) begin
      rvalid[tag_id_q[READ_LATENCY-1]] = 1'b1;
    end
  end

  // FSM, grant and tag-pipe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]   timeout_id_q, timeout_id_d;

  assign hold_expired = in_busy && (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout_err  = timeout_err_q;
  assign timeout_id   = timeout_id_q;

  // Hold counter stays clear while idle, so it starts from zero on every grant;
  // a last beat in the limit cycle wins over the timeout
  always_comb begin
    hold_d        = hold_q;
    timeout_err_d = 1'b0;
    timeout_id_d  = timeout_id_q;
    if (!in_busy) begin
      hold_d = '0;
    end else if (!burst_done) begin
      hold_d = hold_q + 1'b1;
    end
    if (hold_expired && !burst_done) begin
      timeout_err_d = 1'b1;
      timeout_id_d  = owner_q;
    end
  end

  // Timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q        <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      hold_q        <= hold_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout_err  = 1'b0;
  assign timeout_id   = '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed bursts, checked against a
// cycle-level behavioural model of the arbitration rules plus literal
// expectations for each scenario.
module tb_bram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int EXP_HOLD = TO_EN ? MH : 12;
  localparam int EXP_TERR = TO_EN ? 1 : 0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req, last, we;
  logic [N*AW-1:0]      addr;
  logic [N*DW-1:0]      wdata;
  logic [N-1:0]         gnt;
  logic                 bram_en, bram_we;
  logic [AW-1:0]        bram_addr;
  logic [DW-1:0]        bram_wdata, bram_rdata, rdata;
  logic [N-1:0]         rvalid;
  logic                 busy, timeout_err;
  logic [$clog2(N)-1:0] timeout_id;

  bram_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .timeout_err(timeout_err),
    .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM stand-in: read data is 16'hBEEF concatenated with the address, RL cycles later
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= {16'hBEEF, bram_addr};
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RL-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Event logs observed from the DUT, consumed by the directed checks
  typedef struct {int cyc; int id;} gev_t;
  typedef struct {int cyc; logic [AW-1:0] a; logic w;} bev_t;
  typedef struct {int cyc; logic [N-1:0] v; logic [DW-1:0] d;} rev_t;
  typedef struct {int due; int id; logic [AW-1:0] a;} rd_t;
  gev_t glog[$];
  bev_t blog[$];
  rev_t rlog[$];
  gev_t tlog[$];
  int   gcnt[N];
  logic [N-1:0] prev_gnt;

  // Model state: current owner (-1 when none), pointer, hold cycles, pending reads
  int   m_own = -1;
  int   m_ptr = 0;
  int   m_held = 0;
  bit   m_terr = 0;
  int   m_tid = 0;
  rd_t  rdq[$];
  logic [N-1:0]  e_gnt, e_rv;
  logic          e_en, e_we;
  logic [DW-1:0] e_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_held = 0; m_terr = 0; m_tid = 0;
      rdq.delete();
      prev_gnt = '0;
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_bram_en", bram_en, 0);
      check("rst_bram_we", bram_we, 0);
      check("rst_bram_addr", bram_addr, 0);
      check("rst_bram_wdata", bram_wdata, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_timeout_id", timeout_id, 0);
    end else begin
      e_gnt = '0;
      e_en  = 1'b0;
      e_we  = 1'b0;
      if (m_own >= 0) begin
        e_gnt[m_own] = 1'b1;
        e_en = req[m_own];
        e_we = req[m_own] & we[m_own];
      end
      e_rv = '0;
      e_d  = '0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        e_rv[rdq[0].id] = 1'b1;
        e_d = {16'hBEEF, rdq[0].a};
        void'(rdq.pop_front());
      end
      check("gnt", gnt, e_gnt);
      check("busy", busy, m_own >= 0);
      check("bram_en", bram_en, e_en);
      check("bram_we", bram_we, e_we);
      check("rvalid", rvalid, e_rv);
      check("timeout_err", timeout_err, m_terr);
      check("rdata_pass", rdata, bram_rdata);
      if (e_en) check("bram_addr", bram_addr, addr[m_own*AW +: AW]);
      if (e_we) check("bram_wdata", bram_wdata, wdata[m_own*DW +: DW]);
      if (e_rv != 0) check("rdata", rdata, e_d);
      if (m_terr) check("timeout_id", timeout_id, m_tid);

      // Advance the model to the next cycle
      m_terr = 0;
      if (m_own >= 0) begin
        if (e_en && !e_we) rdq.push_back('{cyc + RL, m_own, addr[m_own*AW +: AW]});
        if (e_en && last[m_own]) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end else if (TO_EN && m_held == MH - 1) begin
          m_terr = 1;
          m_tid  = m_own;
          m_ptr  = (m_own + 1) % N;
          m_own  = -1;
        end else begin
          m_held++;
        end
      end else begin
        for (int k = 0; k < N; k++)
          if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
        m_held = 0;
      end

      for (int k = 0; k < N; k++) if (gnt[k]) gcnt[k]++;
      if (gnt != 0 && gnt != prev_gnt)
        for (int k = 0; k < N; k++) if (gnt[k]) glog.push_back('{cyc, k});
      prev_gnt = gnt;
      if (bram_en) blog.push_back('{cyc, bram_addr, bram_we});
      if (rvalid != 0) rlog.push_back('{cyc, rvalid, rdata});
      if (timeout_err) tlog.push_back('{cyc, int'(timeout_id)});
    end
  end

  task automatic clear_logs();
    glog.delete(); blog.delete(); rlog.delete(); tlog.delete();
    for (int k = 0; k < N; k++) gcnt[k] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_lane(input int id, input logic r, input logic l, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[id] = r; last[id] = l; we[id] = w;
    addr[id*AW +: AW] = a;
    wdata[id*DW +: DW] = d;
  endtask

  // Client driver: request, then present one beat per granted cycle, optionally
  // stalling stall_len cycles before beat stall_at; stops on completion or revocation
  task automatic run_burst(input int id, input int n, input bit wr, input int base,
                           input int stride, input int stall_at, input int stall_len,
                           input int exp_beats);
    int b = 0;
    int st = 0;
    int t = 0;
    bit had = 0;
    forever begin
      if (b == n) break;
      if (gnt[id]) begin
        had = 1;
        if (b == stall_at && st < stall_len) begin
          req[id] = 1'b0;
          st++;
        end else begin
          set_lane(id, 1'b1, b == n - 1, wr, AW'(base + b * stride), {16'(id), 16'(b)});
          b++;
        end
      end else begin
        if (had) break;
        set_lane(id, 1'b1, 1'b0, wr, AW'(base), '0);
      end
      if (t == 200) break;
      t++;
      idle(1);
    end
    set_lane(id, 1'b0, 1'b0, 1'b0, '0, '0);
    check($sformatf("beats_c%0d", id), b, exp_beats);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int g;
  int addrs[4] = '{0, 24, 48, 72};

  initial begin
    rst_n = 1'b0;
    req = '0; last = '0; we = '0; addr = '0; wdata = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("reset_gnt", gnt, 0);
    check("reset_busy", busy, 0);
    check("reset_timeout_id", timeout_id, 0);

    // 1: client 0, 4-beat write at 0,24,48,72
    clear_logs();
    run_burst(0, 4, 1'b1, 0, 24, -1, 0, 4);
    idle(2);
    check("t1_gnt_cycles", gcnt[0], 4);
    check("t1_beats", blog.size(), 4);
    if (blog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("t1_addr", blog[i].a, addrs[i]);
        check("t1_we", blog[i].w, 1);
        check("t1_back_to_back", blog[i].cyc - blog[0].cyc, i);
      end
    check("t1_busy_after", busy, 0);

    // 2: three clients with 2-beat bursts, client 0 requests again
    do_reset();
    clear_logs();
    fork
      begin
        run_burst(0, 2, 1'b1, 'h100, 1, -1, 0, 2);
        run_burst(0, 2, 1'b1, 'h180, 1, -1, 0, 2);
      end
      run_burst(1, 2, 1'b1, 'h200, 1, -1, 0, 2);
      run_burst(2, 2, 1'b1, 'h300, 1, -1, 0, 2);
    join
    idle(2);
    check("t2_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      check("t2_order0", glog[0].id, 0);
      check("t2_order1", glog[1].id, 1);
      check("t2_order2", glog[2].id, 2);
      check("t2_order3", glog[3].id, 0);
      check("t2_gap1", glog[1].cyc - glog[0].cyc, 3);
      check("t2_gap2", glog[2].cyc - glog[0].cyc, 6);
      check("t2_gap3", glog[3].cyc - glog[0].cyc, 9);
    end

    // 3: client 1 stalls 3 cycles mid-burst while client 2 waits
    clear_logs();
    fork
      run_burst(1, 3, 1'b1, 'h400, 8, 2, 3, 3);
      run_burst(2, 1, 1'b1, 'h500, 1, -1, 0, 1);
    join
    idle(2);
    check("t3_gnt1_cycles", gcnt[1], 6);
    check("t3_beats", blog.size(), 4);
    check("t3_grants", glog.size(), 2);
    if (glog.size() == 2 && blog.size() == 4) begin
      check("t3_first", glog[0].id, 1);
      check("t3_second", glog[1].id, 2);
      check("t3_wait", glog[1].cyc - glog[0].cyc, 7);
      check("t3_last_beat", blog[2].cyc - glog[0].cyc, 5);
    end

    // 4: client 2 reads addr 5 then 6, client 0 follows with a write
    clear_logs();
    fork
      run_burst(2, 2, 1'b0, 5, 1, -1, 0, 2);
      begin
        idle(1);
        run_burst(0, 1, 1'b1, 'h64, 1, -1, 0, 1);
      end
    join
    idle(4);
    check("t4_gnt0_cycles", gcnt[0], 1);
    check("t4_returns", rlog.size(), 2);
    if (rlog.size() == 2 && glog.size() == 2) begin
      g = glog[0].cyc;
      check("t4_owner", glog[0].id, 2);
      check("t4_next", glog[1].id, 0);
      check("t4_rv0", rlog[0].v, 3'b100);
      check("t4_rv0_cyc", rlog[0].cyc - g, 2);
      check("t4_rd0", rlog[0].d, 32'hBEEF0005);
      check("t4_rv1", rlog[1].v, 3'b100);
      check("t4_rv1_cyc", rlog[1].cyc - g, 3);
      check("t4_rd1", rlog[1].d, 32'hBEEF0006);
    end

    // 5: reset mid read burst by client 1
    set_lane(1, 1'b1, 1'b0, 1'b0, 10, '0);
    idle(1);
    check("t5_gnt", gnt, 3'b010);
    idle(1);
    set_lane(1, 1'b1, 1'b0, 1'b0, 11, '0);
    idle(1);
    clear_logs();
    rst_n = 1'b0;
    set_lane(1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("t5_gnt_rst", gnt, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_en_rst", bram_en, 0);
    check("t5_rvalid_rst", rvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    check("t5_no_returns", rlog.size(), 0);
    clear_logs();
    fork
      run_burst(0, 1, 1'b1, 'h600, 1, -1, 0, 1);
      run_burst(2, 1, 1'b1, 'h700, 1, -1, 0, 1);
    join
    idle(2);
    check("t5_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t5_first", glog[0].id, 0);
      check("t5_second", glog[1].id, 2);
    end

    // 6: client 1 holds past MAX_HOLD without last, client 2 waits
    clear_logs();
    fork
      run_burst(1, 12, 1'b1, 'h800, 1, -1, 0, EXP_HOLD);
      run_burst(2, 1, 1'b1, 'h900, 1, -1, 0, 1);
    join
    idle(3);
    check("t6_hold", gcnt[1], EXP_HOLD);
    check("t6_terr_count", tlog.size(), EXP_TERR);
    check("t6_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t6_first", glog[0].id, 1);
      check("t6_next", glog[1].id, 2);
      check("t6_gap", glog[1].cyc - glog[0].cyc, EXP_HOLD + 1);
      if (tlog.size() == 1) begin
        check("t6_tid", tlog[0].id, 1);
        check("t6_tcyc", tlog[0].cyc - glog[0].cyc, MH);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
